dmem_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer for the single-port data memory.

---
 rtl/dmem_arbiter.sv | 139 +++++++++++++
 tb/tb_dmem_arbiter.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Two-port round-robin arbiter/sequencer for a single-port
//                data memory. Requester 0 (CPU load/store) and requester 1
//                (debug/DMA loader) issue word requests with a req/ack
//                handshake. The winner's request is latched, driven to the
//                memory for exactly one cycle, and the result is returned
//                with a one-cycle ack pulse. Every transaction takes 3 cycles
//                (IDLE -> ACCESS -> DONE).
//  Ports       : clk, rst              - clock, synchronous active-high reset
//                mN_req/we/addr/wdata  - requester N request fields (N=0,1)
//                mN_ack/rdata/err      - requester N completion (valid on ack)
//                mem_we/addr/wr_data   - memory write/address/write-data
//                mem_rd_data           - memory combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_WORDS = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_ack,
    output logic [DATA_W-1:0] m0_rdata,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_ack,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              m1_err,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data
);

    localparam logic [ADDR_W-3:0] c_WORD_LIMIT = (ADDR_W-2)'(MEM_WORDS);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;

    logic                r_prio;
    logic                r_win;
    logic                r_we;
    logic                r_err;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;

    logic                w_any;
    logic                w_win;
    logic                w_sel_we;
    logic [ADDR_W-1:0]   w_sel_addr;
    logic [DATA_W-1:0]   w_sel_wdata;
    logic                w_sel_err;
    logic                w_grant;
    logic                w_done;

    // Winner selection: a lone requester always wins; on contention the
    // requester named by r_prio wins.
    assign w_any       = m0_req | m1_req;
    assign w_win       = (m0_req & m1_req) ? r_prio : m1_req;
    assign w_sel_we    = w_win ? m1_we    : m0_we;
    assign w_sel_addr  = w_win ? m1_addr  : m0_addr;
    assign w_sel_wdata = w_win ? m1_wdata : m0_wdata;
    assign w_sel_err   = (w_sel_addr[1:0] != 2'b00) |
                         (w_sel_addr[ADDR_W-1:2] >= c_WORD_LIMIT);
    assign w_grant     = (r_state == ST_IDLE) & w_any;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:   if (w_any) w_state_nxt = ST_ACCESS;
            ST_ACCESS: w_state_nxt = ST_DONE;
            ST_DONE:   w_state_nxt = ST_IDLE;
            default:   w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_prio  <= 1'b0;
            r_win   <= 1'b0;
            r_we    <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_win   <= w_win;
                r_we    <= w_sel_we;
                r_err   <= w_sel_err;
                r_addr  <= w_sel_addr;
                r_wdata <= w_sel_wdata;
                r_prio  <= ~w_win;
            end
            // Capture read data on the edge that ends ACCESS; writes and
            // faulting accesses return zero.
            if (r_state == ST_ACCESS) begin
                r_rdata <= (r_we | r_err) ? '0 : mem_rd_data;
            end
        end
    end

    // The latched address/data only change on a grant, so driving them
    // directly gives "hold last value" outside ACCESS for free. The write
    // enable is gated with rst combinationally so a reset during ACCESS
    // prevents the write landing on that edge.
    assign mem_addr    = r_addr;
    assign mem_wr_data = r_wdata;
    assign mem_we      = (r_state == ST_ACCESS) & r_we & ~r_err & ~rst;

    assign w_done   = (r_state == ST_DONE);
    assign m0_ack   = w_done & ~r_win;
    assign m1_ack   = w_done &  r_win;
    assign m0_err   = m0_ack & r_err;
    assign m1_err   = m1_ack & r_err;
    assign m0_rdata = {DATA_W{m0_ack}} & r_rdata;
    assign m1_rdata = {DATA_W{m1_ack}} & r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter. A bench-side memory
//                serves the DUT; a transaction-level model predicts grants,
//                write landing, ack timing and returned data, and a compare
//                process checks every output each cycle. Directed tests add
//                literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_req = 1'b0, m0_we = 1'b0;
    logic [31:0] m0_addr = '0, m0_wdata = '0;
    logic        m0_ack, m0_err;
    logic [31:0] m0_rdata;
    logic        m1_req = 1'b0, m1_we = 1'b0;
    logic [31:0] m1_addr = '0, m1_wdata = '0;
    logic        m1_ack, m1_err;
    logic [31:0] m1_rdata;
    logic        mem_we;
    logic [31:0] mem_addr, mem_wr_data, mem_rd_data;

    always #5 clk = ~clk;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_WORDS(32)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ack(m0_ack), .m0_rdata(m0_rdata), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ack(m1_ack), .m1_rdata(m1_rdata), .m1_err(m1_err),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
        .mem_rd_data(mem_rd_data)
    );

    // Physical memory seen by the DUT
    logic [31:0] pmem [32];
    assign mem_rd_data = pmem[mem_addr[6:2]];
    always @(posedge clk) if (mem_we) pmem[mem_addr[6:2]] <= mem_wr_data;

    int n_chk = 0;
    int n_err = 0;
    int cyc   = 0;   // index of the interval following the latest posedge
    int we_cnt = 0;  // intervals with mem_we high

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- transaction-level model ----------------
    logic [31:0] ref_mem [32];
    bit          t_have = 0;
    int          t_g = -10;      // grant edge index
    int          free_at = 0;    // first edge at which a new grant is possible
    bit          m_prio = 0;
    bit          t_win;
    bit          t_we, t_err;
    logic [31:0] t_addr, t_wd, t_rd;
    logic [31:0] ex_addr = '0, ex_wd = '0;

    initial begin
        for (int i = 0; i < 32; i++) begin
            pmem[i]    = 32'hA5A5_0000 + i;
            ref_mem[i] = 32'hA5A5_0000 + i;
        end
    end

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (rst) begin
            t_have = 0; m_prio = 0; free_at = 0; ex_addr = '0; ex_wd = '0;
        end else begin
            if (t_have && cyc == t_g + 1 && t_we && !t_err)
                ref_mem[t_addr[6:2]] = t_wd;
            if (cyc >= free_at && (m0_req || m1_req)) begin
                t_win  = (m0_req && m1_req) ? m_prio : m1_req;
                t_we   = t_win ? m1_we : m0_we;
                t_addr = t_win ? m1_addr : m0_addr;
                t_wd   = t_win ? m1_wdata : m0_wdata;
                t_err  = (t_addr % 4 != 0) || (t_addr / 4 >= 32);
                t_rd   = (t_we || t_err) ? 32'h0 : ref_mem[t_addr[6:2]];
                t_have = 1; t_g = cyc; free_at = cyc + 3; m_prio = !t_win;
                ex_addr = t_addr; ex_wd = t_wd;
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        bit e_we, e_a0, e_a1;
        if (mem_we === 1'b1) we_cnt++;
        if (cyc >= 1) begin
            e_we = t_have && cyc == t_g && t_we && !t_err && !rst;
            e_a0 = t_have && cyc == t_g + 1 && !t_win;
            e_a1 = t_have && cyc == t_g + 1 && t_win;
            chk("mem_we",      {31'b0, mem_we}, {31'b0, e_we});
            chk("mem_addr",    mem_addr, ex_addr);
            chk("mem_wr_data", mem_wr_data, ex_wd);
            chk("m0_ack",      {31'b0, m0_ack}, {31'b0, e_a0});
            chk("m1_ack",      {31'b0, m1_ack}, {31'b0, e_a1});
            chk("m0_rdata",    m0_rdata, e_a0 ? t_rd : 32'h0);
            chk("m1_rdata",    m1_rdata, e_a1 ? t_rd : 32'h0);
            chk("m0_err",      {31'b0, m0_err}, {31'b0, e_a0 && t_err});
            chk("m1_err",      {31'b0, m1_err}, {31'b0, e_a1 && t_err});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic wait_ack(input int id, output int c, output logic [31:0] rd, output logic er);
        bit got = 0;
        c = -1; rd = 'x; er = 1'bx;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk);
            if ((id == 0 && m0_ack) || (id == 1 && m1_ack)) begin
                got = 1; c = cyc;
                rd = (id == 0) ? m0_rdata : m1_rdata;
                er = (id == 0) ? m0_err : m1_err;
            end
        end
        if (!got) chk("ack_timeout", 32'h0, 32'h1);
    endtask

    task automatic drive(input int id, input logic req, input logic we,
                         input logic [31:0] a, input logic [31:0] d);
        if (id == 0) begin m0_req = req; m0_we = we; m0_addr = a; m0_wdata = d; end
        else         begin m1_req = req; m1_we = we; m1_addr = a; m1_wdata = d; end
    endtask

    task automatic txn(input int id, input logic we, input logic [31:0] a,
                       input logic [31:0] d, output logic [31:0] rd,
                       output logic er, output int lat);
        int r, c;
        @(posedge clk); #1;
        drive(id, 1'b1, we, a, d);
        r = cyc;
        wait_ack(id, c, rd, er);
        lat = c - r;
        @(posedge clk); #1;
        drive(id, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    task automatic do_reset(input int n);
        @(posedge clk); #1; rst = 1'b1;
        repeat (n) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int q_id[$];
    int q_cy[$];
    task automatic both_run(input int n);
        q_id.delete(); q_cy.delete();
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b0, 32'h10, 32'h0);
        drive(1, 1'b1, 1'b0, 32'h14, 32'h0);
        for (int i = 0; i < n * 3 + 6 && q_id.size() < n; i++) begin
            @(negedge clk);
            if (m0_ack) begin q_id.push_back(0); q_cy.push_back(cyc); end
            if (m1_ack) begin q_id.push_back(1); q_cy.push_back(cyc); end
        end
        if (q_id.size() != n) chk("both_ack_count", q_id.size(), n);
        @(posedge clk); #1;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat, w0, c1, c2;

        // 1: reset state, then contention from reset favours m0
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", {m0_ack, m1_ack, m0_err, m1_err, mem_we},  5'b0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_rdata", m0_rdata | m1_rdata | mem_wr_data, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        both_run(2);
        if (q_id.size() == 2) begin
            chk("first_grant_m0", q_id[0], 0);
            chk("second_grant_m1", q_id[1], 1);
        end

        // 2: m0 write then read back
        w0 = we_cnt;
        txn(0, 1'b1, 32'h8, 32'hDEAD_BEEF, rd, er, lat);
        chk("wr_latency", lat, 2);
        chk("wr_err", {31'b0, er}, 32'h0);
        chk("wr_we_cycles", we_cnt - w0, 1);
        txn(0, 1'b0, 32'h8, 32'h0, rd, er, lat);
        chk("rd_back", rd, 32'hDEAD_BEEF);
        chk("rd_latency", lat, 2);

        // 3: sustained contention alternates, one ack every 3 cycles
        do_reset(1);
        both_run(4);
        if (q_id.size() == 4) begin
            for (int i = 0; i < 4; i++) chk("alt_order", q_id[i], i % 2);
            for (int i = 1; i < 4; i++) chk("alt_spacing", q_cy[i] - q_cy[i-1], 3);
        end

        // 4: error transactions
        w0 = we_cnt;
        txn(1, 1'b1, 32'h6, 32'hCAFE_F00D, rd, er, lat);
        chk("misalign_err", {31'b0, er}, 32'h1);
        chk("misalign_no_we", we_cnt - w0, 0);
        txn(1, 1'b0, 32'h80, 32'h0, rd, er, lat);
        chk("oor_err", {31'b0, er}, 32'h1);
        chk("oor_rdata", rd, 32'h0);
        chk("oor_latency", lat, 2);

        // 5: reset during ACCESS of a write drops it
        w0 = we_cnt;
        @(posedge clk); #1;
        drive(0, 1'b1, 1'b1, 32'h4, 32'h1234_5678);
        @(posedge clk); #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_access_we", {31'b0, mem_we}, 32'h0);
        @(posedge clk); #1 rst = 1'b0;
        drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
        repeat (3) @(negedge clk);
        chk("rst_access_no_we", we_cnt - w0, 0);
        txn(0, 1'b0, 32'h4, 32'h0, rd, er, lat);
        chk("rst_old_value", rd, 32'hA5A5_0001);

        // 6: holding req one cycle past ack re-issues the transaction
        @(posedge clk); #1;
        drive(1, 1'b1, 1'b0, 32'h8, 32'h0);
        wait_ack(1, c1, rd, er);
        chk("hold_rd1", rd, 32'hDEAD_BEEF);
        @(posedge clk); #1;
        @(posedge clk); #1;
        drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
        wait_ack(1, c2, rd, er);
        chk("hold_rd2", rd, 32'hDEAD_BEEF);
        chk("hold_spacing", c2 - c1, 3);

        repeat (4) @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
